gpio_bus_initiator: RTL



---
 rtl/gpio_bus_pkg.sv | 22 ++
 rtl/gpio_bus_initiator_if.sv | 26 ++
 rtl/gpio_bus_initiator.sv | 78 +++++++
 3 files changed

// File: rtl/gpio_bus_pkg.sv
// gpio_bus_pkg: opcodes, GPIO register offsets and initiator FSM states shared by the GPIO bus initiator
package gpio_bus_pkg;
    localparam logic [2:0] OP_WR_DATA   = 3'd0;
    localparam logic [2:0] OP_WR_DIR    = 3'd1;
    localparam logic [2:0] OP_RMW_DATA  = 3'd2;
    localparam logic [2:0] OP_RMW_DIR   = 3'd3;
    localparam logic [2:0] OP_TGL_DATA  = 3'd4;
    localparam logic [2:0] OP_RD_PINS   = 3'd5;
    localparam logic [2:0] OP_RD_DATA   = 3'd6;
    localparam logic [2:0] OP_WAIT_PINS = 3'd7;

    localparam logic [31:0] GPIO_DATA_OFF = 32'h00;
    localparam logic [31:0] GPIO_DIR_OFF  = 32'h04;
    localparam logic [31:0] GPIO_READ_OFF = 32'h08;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    function automatic logic [31:0] reg_off(input logic [2:0] op);
        return (op == OP_RD_PINS || op == OP_WAIT_PINS) ? GPIO_READ_OFF :
               (op == OP_WR_DIR || op == OP_RMW_DIR) ? GPIO_DIR_OFF : GPIO_DATA_OFF;
    endfunction
endpackage

// File: rtl/gpio_bus_initiator_if.sv
// gpio_bus_initiator_if: command, response and GPIO bus signals of the initiator
interface gpio_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready, bus_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, bus_valid, bus_we, bus_addr, bus_wdata
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, bus_valid, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/gpio_bus_initiator.sv
// gpio_bus_initiator: turns write/RMW/toggle/read/wait-pins commands into single-cycle GPIO bus transfers
module gpio_bus_initiator
    import gpio_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 1000,
    parameter int          TIMEOUT_W = 16
) (
    input logic clk,
    input logic rst,
    gpio_bus_initiator_if.master m
);
    state_t                 state, state_nxt;
    logic [2:0]             op;
    logic [31:0]            data, mask, wval, rsp_q;
    logic                   err_q;
    logic [TIMEOUT_W-1:0]   cnt;
    logic                   hit, last;

    assign hit  = ((m.bus_rdata ^ data) & mask) == '0;
    // this miss is the TIMEOUT-th poll
    assign last = cnt >= TIMEOUT_W'(TIMEOUT - 1);

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m.cmd_valid) state_nxt = (m.cmd_op <= OP_WR_DIR) ? WR : RD;
            RD:      state_nxt = (op <= OP_TGL_DATA) ? WR :
                                 (op != OP_WAIT_PINS || hit || last) ? RSP : RD;
            WR:      state_nxt = RSP;
            RSP:     if (m.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op    <= '0;
            data  <= '0;
            mask  <= '0;
            wval  <= '0;
            cnt   <= '0;
            rsp_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && m.cmd_valid) begin
                op   <= m.cmd_op;
                data <= m.cmd_data;
                mask <= m.cmd_mask;
                wval <= m.cmd_data;
                cnt  <= '0;
            end
            if (state == RD) begin
                wval  <= (op == OP_TGL_DATA) ? m.bus_rdata ^ mask : (m.bus_rdata & ~mask) | (data & mask);
                rsp_q <= m.bus_rdata;
                err_q <= op == OP_WAIT_PINS && !hit && last;
                if (op == OP_WAIT_PINS && !hit && cnt != TIMEOUT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
            end
            if (state == WR) begin
                rsp_q <= wval;
                err_q <= 1'b0;
            end
        end
    end

    assign m.cmd_ready = state == IDLE;
    assign m.rsp_valid = state == RSP;
    assign m.rsp_data  = rsp_q;
    assign m.rsp_err   = err_q;
    assign m.bus_valid = state == RD || state == WR;
    assign m.bus_we    = state == WR;
    assign m.bus_addr  = m.bus_valid ? BASE_ADDR + reg_off(op) : '0;
    assign m.bus_wdata = m.bus_we ? wval : '0;
endmodule
